// File: rtl/blink_meter_if.sv
// rtl/blink_meter_if.sv - bundle of the toggle input and the measurement outputs of blink_meter
interface blink_meter_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 blink_in;
  logic [CNT_WIDTH-1:0] period;
  logic                 period_valid;
  logic                 stalled;
  logic [7:0]           meas_count;

  modport master (
    input  blink_in,
    output period,
    output period_valid,
    output stalled,
    output meas_count
  );

  modport slave (
    output blink_in,
    input  period,
    input  period_valid,
    input  stalled,
    input  meas_count
  );
endinterface

// File: rtl/blink_meter.sv
// rtl/blink_meter.sv - measures clk cycles between toggles of an asynchronous input, flags a stall
module blink_meter #(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 1000
) (
  input  logic         clk,
  input  logic         rst,
  blink_meter_if.master bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] STALL   = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_TIMEOUT = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  logic                 s1;
  logic                 s2;
  logic                 hist;
  logic [1:0]           settle;
  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 accept;

  // Edges are ignored until the synchronizer has flushed its reset contents,
  // so a line already high at reset release is not taken as a toggle.
  assign accept = (settle == 2'd3) && (s2 ^ hist);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1               <= 1'b0;
      s2               <= 1'b0;
      hist             <= 1'b0;
      settle           <= 2'd0;
      state            <= IDLE;
      cnt              <= '0;
      bus.period       <= '0;
      bus.period_valid <= 1'b0;
      bus.stalled      <= 1'b0;
      bus.meas_count   <= 8'd0;
    end else begin
      s1   <= bus.blink_in;
      s2   <= s1;
      hist <= s2;
      if (settle != 2'd3) begin
        settle <= settle + 2'd1;
      end
      bus.period_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            state <= MEASURE;
            cnt   <= CNT_ONE;
          end
        end
        MEASURE: begin
          if (accept) begin
            cnt              <= CNT_ONE;
            bus.period       <= cnt;
            bus.period_valid <= 1'b1;
            bus.meas_count   <= bus.meas_count + 8'd1;
          end else begin
            if (cnt != '1) begin
              cnt <= cnt + CNT_ONE;
            end
            if (cnt == CNT_TIMEOUT) begin
              state       <= STALL;
              bus.stalled <= 1'b1;
            end
          end
        end
        STALL: begin
          // The stalled interval is meaningless, so re-arm without a strobe.
          if (accept) begin
            state       <= MEASURE;
            cnt         <= CNT_ONE;
            bus.stalled <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blink_meter.sv
// tb/tb_blink_meter.sv - directed self-checking bench for blink_meter
module tb_blink_meter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   exp_meas;
  int   pv_seen;

  blink_meter_if #(.CNT_WIDTH(16)) bus ();

  blink_meter #(
    .CNT_WIDTH(16),
    .TIMEOUT  (50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic toggle();
    bus.blink_in = ~bus.blink_in;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_period"}, int'(bus.period), 0);
    check({tag, "_valid"}, int'(bus.period_valid), 0);
    check({tag, "_stalled"}, int'(bus.stalled), 0);
    check({tag, "_meas"}, int'(bus.meas_count), 0);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    exp_meas    = 0;
    rst         = 1'b1;
    bus.blink_in = 1'b0;
    step(2);
    rst = 1'b0;
    check_reset_outputs("reset");
    step(3);

    // Steady blink, half-period 12: first toggle only arms
    for (int i = 0; i < 4; i++) begin
      toggle();
      step(3);
      if (i == 0) begin
        check("arm_valid", int'(bus.period_valid), 0);
      end else begin
        exp_meas = exp_meas + 1;
        check("steady_valid", int'(bus.period_valid), 1);
        check("steady_period", int'(bus.period), 12);
        check("steady_meas", int'(bus.meas_count), exp_meas);
      end
      step(1);
      check("steady_strobe_len", int'(bus.period_valid), 0);
      check("steady_hold", int'(bus.period), (i == 0) ? 0 : 12);
      step(8);
    end

    // Rate change to half-period 5
    for (int j = 0; j < 3; j++) begin
      toggle();
      step(3);
      exp_meas = exp_meas + 1;
      check("rate5_valid", int'(bus.period_valid), 1);
      check("rate5_period", int'(bus.period), (j == 0) ? 12 : 5);
      check("rate5_meas", int'(bus.meas_count), exp_meas);
      step(2);
    end

    // Half-period 1, long enough to wrap meas_count
    for (int i = 0; i < 300; i++) begin
      toggle();
      step(1);
      if (i >= 2) begin
        exp_meas = (exp_meas + 1) % 256;
        check("rate1_valid", int'(bus.period_valid), 1);
        check("rate1_period", int'(bus.period), (i == 2) ? 5 : 1);
        check("rate1_meas", int'(bus.meas_count), exp_meas);
      end
    end
    step(60);
    check("after_fast_stalled", int'(bus.stalled), 1);

    // Stall recovery, then a fresh stall timed from the last edge
    toggle();
    step(3);
    check("recover_stalled", int'(bus.stalled), 0);
    check("recover_valid", int'(bus.period_valid), 0);
    step(9);
    toggle();
    step(3);
    check("stall_pre_valid", int'(bus.period_valid), 1);
    check("stall_pre_period", int'(bus.period), 12);
    step(49);
    check("stall_not_yet", int'(bus.stalled), 0);
    step(1);
    check("stall_rise", int'(bus.stalled), 1);
    check("stall_valid", int'(bus.period_valid), 0);
    step(5);
    toggle();
    step(3);
    check("stall_exit", int'(bus.stalled), 0);
    check("stall_exit_valid", int'(bus.period_valid), 0);
    check("stall_exit_period", int'(bus.period), 12);
    step(17);
    toggle();
    step(3);
    check("post_stall_valid", int'(bus.period_valid), 1);
    check("post_stall_period", int'(bus.period), 20);

    // Reset 6 cycles after a toggle discards the interval
    step(5);
    toggle();
    step(6);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_reset_outputs("midreset");
    step(3);
    toggle();
    step(3);
    check("midreset_arm_valid", int'(bus.period_valid), 0);
    check("midreset_arm_period", int'(bus.period), 0);
    step(9);
    toggle();
    step(3);
    check("midreset_period", int'(bus.period), 12);
    check("midreset_meas", int'(bus.meas_count), 1);

    // Input high through reset: no edge must be accepted
    rst = 1'b1;
    bus.blink_in = 1'b1;
    step(2);
    rst = 1'b0;
    pv_seen = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (bus.period_valid) pv_seen = pv_seen + 1;
    end
    check("high_reset_strobes", pv_seen, 0);
    check("high_reset_stalled", int'(bus.stalled), 0);
    check("high_reset_meas", int'(bus.meas_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/blink_meter.md
# blink_meter

Receive-side companion to the LED blinker. It samples an asynchronous toggling input (an LED drive line or another board's blink output) and measures the number of `clk` cycles between consecutive toggles. Each measured half-period is presented with a one-cycle valid strobe, and a stall flag rises when the input stops toggling. It sits at board-level inputs and is used for self-test loopback and for cross-board heartbeat checks.

## Interface
- `CNT_WIDTH`, default 16: width of the interval counter and of `period`.
- `TIMEOUT`, default 1000: cycles without a toggle before `stalled` rises.
  - Must satisfy 2 ≤ `TIMEOUT` < 2^`CNT_WIDTH`.
- `clk` input, 1 bit: single clock; every flop is on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `blink_in` input, 1 bit: asynchronous toggling signal.
- `period` output, `CNT_WIDTH` bits: last measured cycles between toggles. Reset value 0.
- `period_valid` output, 1 bit: one-cycle strobe; `period` was updated this cycle. Reset value 0.
- `stalled` output, 1 bit: level; no toggle seen for `TIMEOUT` cycles. Reset value 0.
- `meas_count` output, 8 bits: number of valid measurements, wraps 255→0. Reset value 0.

## Operation
- **Synchronizer.** Two flops `s1` and `s2` feed a history flop `hist`.
  - `edge = s2 ^ hist`.
  - All three flops reset to 0.
- **Settle counter (2 bits).**
  - Cleared by reset; counts up to 3 and then holds.
  - While it is below 3, `edge` is ignored, so that `blink_in` being high at reset release does not register as a toggle.
- **Interval counter `cnt`.**
  - On a cycle with an accepted edge: `cnt <= 1`.
  - Otherwise in MEASURE: `cnt <= cnt + 1`.
  - In IDLE and STALL: `cnt` holds.
  - Never wraps.
- **State IDLE** (after reset): first accepted edge → MEASURE. No strobe.
- **State MEASURE.**
  - Accepted edge: `period <= cnt`, `period_valid <= 1`, `meas_count <= meas_count + 1`. Stay in MEASURE.
  - No edge and `cnt == TIMEOUT`: go to STALL with `stalled <= 1`.
  - If an edge and the timeout occur in the same cycle, the edge wins: measurement taken, no stall.
- **State STALL.**
  - Accepted edge → MEASURE with `cnt <= 1` and `stalled <= 0`.
  - No strobe on this edge, because the stalled interval is discarded.
- **Outputs between measurements.**
  - `period` holds its last value.
  - `period_valid` is 0 on every cycle without a measurement.
- **Reset mid-operation.** On the clock edge where `rst` is high:
  - All outputs and state return to their reset values.
  - Any in-flight interval is discarded.

## Timing
- Let `blink_in` change before rising edge k.
  - `s1` captures it at k, `s2` at k+1.
  - `edge` is high during the cycle between k+1 and k+2.
  - Registered outputs update at k+2, so latency is 2 cycles from sampling to the `period_valid` cycle.
- `period` equals the exact cycle distance between the two edge-detect cycles. Synchronizer delay cancels out.
- A toggle on every cycle gives `period` = 1 with `period_valid` high continuously.
- `stalled` rises on the clock edge after the cycle where `cnt == TIMEOUT`. That is `TIMEOUT` + 1 cycles after the last edge-detect cycle.
- The first `period_valid` after reset needs two accepted toggles: one to arm and one to measure.

## Test plan
- **Steady blink.** Reset, then `blink_in` toggles every 12 cycles.
  - First toggle: no strobe.
  - Second and later toggles: `period` = 12 with a one-cycle strobe each.
  - `meas_count` reads 1, 2, 3…
- **Input high through reset.** `blink_in` = 1 during and after reset, with no toggles.
  - No edge is accepted; state remains IDLE.
  - `period_valid` stays 0 for 100 cycles.
- **Stall and recovery.** `TIMEOUT` = 50; toggle twice 12 cycles apart, then hold.
  - `stalled` = 1 exactly 51 cycles after the last edge-detect cycle.
  - Next toggle: `stalled` = 0 and no strobe.
  - Toggle 20 cycles later: `period` = 20.
- **Rate change and minimum.** Half-period of 12, then 5, then 1.
  - `period` reports 12, then 5, then 1.
  - At half-period 1, `period_valid` is high continuously.
- **Reset mid-interval.** Assert `rst` 6 cycles after a toggle.
  - All outputs are 0 on the next cycle.
  - The next toggle only arms; no stale `period` appears.
- **Counter wrap.** 256 valid measurements → `meas_count` wraps from 255 to 0.
